// File: rtl/imem_pkg.sv
// Shared widths and the response record for the instruction-memory responder.
// The record carries one fetched instruction together with the PC it was read from.
package imem_pkg;

    localparam int IMEM_AW     = 9;
    localparam int IMEM_DW     = 32;
    localparam int IMEM_DEPTH  = 4;
    localparam int IMEM_RD_LAT = 1;

    typedef struct packed {
        logic [IMEM_DW-1:0] instr;
        logic [IMEM_AW-1:0] pc;
    } imem_rsp_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response queue of imem_rsp_t entries with a combinational head read.
// The head must be visible in the cycle after a write, so the storage is read asynchronously.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  imem_rsp_t wr_data,
    input  logic      pop,
    input  logic      clear,
    output imem_rsp_t rd_data,
    output logic      empty,
    output logic      full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    imem_rsp_t        mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst && !clear) begin
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: issues BRAM reads for accepted PCs and returns {instr, pc} in order.
// Optional statistics counters are enabled by defining IMEM_STATS_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int AW     = IMEM_AW,
    parameter int DW     = IMEM_DW,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int RD_LAT = IMEM_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_pc,
    input  logic          flush,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_instr,
    output logic [AW-1:0] rsp_pc
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]   stat_req_cnt,
    output logic [31:0]   stat_stall_cnt
`endif
);

    localparam int OW = occ_width(DEPTH);

    logic [OW-1:0] occ_reg;
    logic [OW-1:0] occ_next;
    logic          accept;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic          exit_vld;
    logic [AW-1:0] exit_pc;
    imem_rsp_t     fifo_wr;
    imem_rsp_t     fifo_rd;

    // occ counts reads in flight plus queued entries, so an accept is only
    // granted when a queue slot is guaranteed for its returning data.
    assign req_ready = rst && !flush && (occ_reg < OW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign mem_en    = accept;
    assign mem_addr  = req_pc;

    assign rsp_valid = rst && !fifo_empty && !flush;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        occ_next = occ_reg;
        case ({accept, pop})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    // PC delay line aligned with the BRAM read latency.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_dly
            logic          vld_reg;
            logic [AW-1:0] pc_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst || flush) begin
                        vld_reg <= 1'b0;
                    end else begin
                        vld_reg <= accept;
                    end
                    pc_reg <= req_pc;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst || flush) begin
                        vld_reg <= 1'b0;
                    end else begin
                        vld_reg <= g_dly[gi-1].vld_reg;
                    end
                    pc_reg <= g_dly[gi-1].pc_reg;
                end
            end
        end
    endgenerate

    assign exit_vld = g_dly[RD_LAT-1].vld_reg;
    assign exit_pc  = g_dly[RD_LAT-1].pc_reg;

    assign fifo_wr.instr = mem_rdata;
    assign fifo_wr.pc    = exit_pc;

    imem_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (exit_vld),
        .wr_data (fifo_wr),
        .pop     (pop),
        .clear   (flush),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign rsp_instr = fifo_rd.instr;
    assign rsp_pc    = fifo_rd.pc;

    // Returning data landing on a full queue means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(exit_vld && fifo_full && !pop));
        end
    end

`ifdef IMEM_STATS_EN
    logic [31:0] stat_req_cnt_reg;
    logic [31:0] stat_stall_cnt_reg;

    // Saturating counters; a flush deliberately leaves them untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_req_cnt_reg   <= '0;
            stat_stall_cnt_reg <= '0;
        end else begin
            if (accept && (stat_req_cnt_reg != 32'hFFFF_FFFF)) begin
                stat_req_cnt_reg <= stat_req_cnt_reg + 32'd1;
            end
            if (rsp_valid && !rsp_ready && (stat_stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stat_stall_cnt_reg <= stat_stall_cnt_reg + 32'd1;
            end
        end
    end

    assign stat_req_cnt   = stat_req_cnt_reg;
    assign stat_stall_cnt = stat_stall_cnt_reg;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: reset, streaming, backpressure, flush, wrap, mid-stream reset,
// and the IMEM_STATS_EN counters when that macro is defined.
module tb_imem_responder;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_pc;
    logic          flush;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_instr;
    logic [AW-1:0] rsp_pc;
`ifdef IMEM_STATS_EN
    logic [31:0]   stat_req_cnt;
    logic [31:0]   stat_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .flush     (flush),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc)
`ifdef IMEM_STATS_EN
        ,
        .stat_req_cnt   (stat_req_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [AW-1:0] pc);
        return 32'hC0DE_0000 ^ {pc, 23'd0} ^ {23'd0, pc};
    endfunction

    // Single-cycle-latency instruction BRAM model.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= instr_of(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_pc;
    logic [63:0]   rdy_pat;
    int            acc;
    int            got;
    int            mocc;

    initial begin
        rst       = 1'b0;
        req_valid = 1'b1;
        req_pc    = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
        end
        rst = 1'b1;

        // Streaming PCs 0..7, responses two cycles after accept.
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8);
            req_pc    = AW'(c);
            #1;
            if (c < 8) begin
                chk("str_req_ready", req_ready, 1);
                chk("str_mem_addr", mem_addr, 64'(c));
            end
            if (c >= 2 && c < 10) begin
                chk("str_rsp_valid", rsp_valid, 1);
                chk("str_rsp_pc", rsp_pc, 64'(c - 2));
                chk("str_rsp_instr", rsp_instr, instr_of(AW'(c - 2)));
            end else begin
                chk("str_idle", rsp_valid, 0);
            end
            step();
        end

        // Backpressure: four accepts fill the credits.
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_pc    = AW'(9'h10 + ((c < 4) ? c : 4));
            #1;
            chk("bp_req_ready", req_ready, (c < 4) ? 1 : 0);
            if (c >= 2) begin
                chk("bp_head_valid", rsp_valid, 1);
                chk("bp_head_pc", rsp_pc, 64'h10);
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 4) begin
                chk("bp_rsp_valid", rsp_valid, 1);
                chk("bp_rsp_pc", rsp_pc, 64'(16 + c));
                chk("bp_rsp_instr", rsp_instr, instr_of(AW'(16 + c)));
            end else begin
                chk("bp_drained", rsp_valid, 0);
            end
            chk("bp_ready_back", req_ready, (c == 0) ? 0 : 1);
            step();
        end

        // Flush drops 0x20/0x21; 0x40 is the first response afterwards.
        req_valid = 1'b1;
        req_pc    = 9'h20;
        #1;
        chk("fl_acc20", req_ready, 1);
        step();
        req_pc = 9'h21;
        #1;
        chk("fl_acc21", req_ready, 1);
        step();
        req_valid = 1'b0;
        flush     = 1'b1;
        #1;
        chk("fl_rsp_valid", rsp_valid, 0);
        chk("fl_req_ready", req_ready, 0);
        step();
        flush     = 1'b0;
        req_valid = 1'b1;
        req_pc    = 9'h40;
        #1;
        chk("fl_post_ready", req_ready, 1);
        chk("fl_post_idle0", rsp_valid, 0);
        step();
        req_valid = 1'b0;
        #1;
        chk("fl_post_idle1", rsp_valid, 0);
        step();
        #1;
        chk("fl_40_valid", rsp_valid, 1);
        chk("fl_40_pc", rsp_pc, 64'h40);
        chk("fl_40_instr", rsp_instr, instr_of(9'h40));
        step();
        #1;
        chk("fl_40_only", rsp_valid, 0);

        // Wrap: 20 requests under a fixed stall pattern with a model of occupancy.
        rdy_pat = 64'hFFFF_FFFF_F0F0_A00F;
        acc  = 0;
        got  = 0;
        mocc = 0;
        for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
            req_valid = (acc < 20);
            req_pc    = AW'(9'h80 + acc);
            rsp_ready = rdy_pat[cyc % 64];
            #1;
            chk("wr_req_ready", req_ready, (mocc < 4) ? 1 : 0);
            if (req_valid && req_ready) begin
                exp_q.push_back(req_pc);
                acc++;
                mocc++;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("wr_extra_rsp", rsp_valid, 0);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk("wr_rsp_pc", rsp_pc, 64'(exp_pc));
                    chk("wr_rsp_instr", rsp_instr, instr_of(exp_pc));
                    got++;
                    mocc--;
                end
            end
            step();
        end
        chk("wr_delivered", 64'(got), 20);
        rsp_ready = 1'b1;
        req_valid = 1'b0;

        // Reset mid-stream: nothing in flight survives.
        req_valid = 1'b1;
        req_pc    = 9'h60;
        step();
        req_pc = 9'h61;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("mrst_rsp_valid", rsp_valid, 0);
            chk("mrst_req_ready", req_ready, 0);
            step();
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mrst_no_rsp", rsp_valid, 0);
            step();
        end

`ifdef IMEM_STATS_EN
        // Counters: 10 accepts, 5 stalled cycles, unaffected by flush.
        chk("st_req_zero", stat_req_cnt, 0);
        chk("st_stall_zero", stat_stall_cnt, 0);
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 9);
            req_pc    = AW'(c);
            rsp_ready = 1'b1;
            step();
        end
        req_valid = 1'b1;
        req_pc    = 9'h50;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("st_stall_valid", rsp_valid, 1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("st_50_pc", rsp_pc, 64'h50);
        step();
        #1;
        chk("st_req_cnt", stat_req_cnt, 10);
        chk("st_stall_cnt", stat_stall_cnt, 5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("st_req_after_flush", stat_req_cnt, 10);
        chk("st_stall_after_flush", stat_stall_cnt, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
